instr_issue_unit: RTL and testbench
===================================

// Module: instr_issue_unit
// PURPOSE
// - Upstream issue stage for the 3-stage ALU pipeline (reg read -> ALU -> writeback/store).
// - Holds a small loadable instruction memory, steps a PC, decodes each word into
//   rs1/rs2/rd/func/addr and presents one instruction per clock with a valid strobe.
// - Interlocks read-after-write hazards against recently issued rd values by inserting bubbles.
// PARAMETERS
// - IMEM_DEPTH  16  instruction words held; AW = $clog2(IMEM_DEPTH)
// - HAZ_DIST    2   issue slots after a write during which its rd is unreadable (1..3)
// PORTS
// - clk1      in   1     single clock, rising edge
// - rst_n     in   1     asynchronous active-low reset
// - ld_en     in   1     write ld_data into imem[ld_addr]
// - ld_addr   in   AW    load address
// - ld_data   in   22    instr: [21:20] func, [19:16] rd, [15:12] rs1, [11:8] rs2, [7:0] addr
// - start     in   1     begin executing imem[0 .. prog_len-1]
// - prog_len  in   AW+1  number of instructions, sampled with start
// - busy      out  1     high RUN..DRAIN
// - done      out  1     one-cycle pulse at program end
// - iss_valid out  1     fields below carry a real instruction this cycle
// - rs1,rs2,rd out 4     decoded register fields
// - func      out  2     decoded ALU op
// - addr      out  8     decoded store address
// - pc        out  AW    index of next instruction to issue
// - stall_cnt out  16    bubbles inserted by interlock, saturates at 16'hFFFF
// BEHAVIOUR
// - Reset (async, any state): state IDLE; every output 0; scoreboard cleared; imem not cleared.
// - FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE. start ignored outside IDLE.
// - IDLE: ld_en writes imem; start with prog_len!=0 -> RUN, pc=0, stall_cnt=0; prog_len=0 -> DONE.
//   prog_len > IMEM_DEPTH clamps to IMEM_DEPTH. ld_en ignored in every state but IDLE.
// - Latency: start sampled at edge N; first iss_valid=1 after edge N+1 (registered outputs).
// - RUN, per edge: decode imem[pc]; if no hazard -> register fields, iss_valid=1, pc+1;
//   if hazard -> iss_valid=0, fields and pc held, stall_cnt+1 (saturating).
// - Hazard: (rs1==sb_rd[i] || rs2==sb_rd[i]) && sb_v[i], i=0..HAZ_DIST-1. Scoreboard shifts every
//   RUN/DRAIN edge; issued slot shifts in {rd,1}, bubble shifts in {x,0}. rd self-overlap is no hazard.
// - Max consecutive bubbles per instruction = HAZ_DIST.
// - Issue of instruction prog_len-1 -> DRAIN: HAZ_DIST+1 cycles of iss_valid=0 so the pipeline
//   flushes -> DONE: done=1 one cycle, busy=0 -> IDLE. pc wraps to 0 on entering IDLE.
// - busy=1 from the edge entering RUN to the edge leaving DRAIN.
// - When iss_valid=0, field outputs hold last issued values; downstream gates on iss_valid.
// - Reset mid-run aborts with no done pulse; no partial instruction survives.
// CONFIGURATION
// - HAZARD_STALL_EN defined: scoreboard and interlock as above.
// - Undefined: no compare, one instruction per RUN cycle unconditionally, scoreboard removed,
//   stall_cnt tied 0, DRAIN still HAZ_DIST+1 cycles.
// TESTING
// - Reset: rst_n=0 for 3 cycles mid-RUN -> busy, iss_valid, done, pc, stall_cnt all 0 immediately.
// - Independent: load {0,1,5,3,125},{1,2,6,4,126},{0,3,7,5,127}, prog_len=3, start -> iss_valid
//   high 3 consecutive cycles with fields in order, stall_cnt=0, done after 3 DRAIN cycles.
// - Distance-1 RAW: i0 rd=1, i1 rs1=1 -> i1 issued 3 cycles after i0 (2 bubbles), stall_cnt=2.
// - Distance-2 RAW: i0 rd=1, i1 independent, i2 rs2=1 -> exactly 1 bubble before i2, stall_cnt=1.
// - Edges: prog_len=0 -> done pulse one cycle after start, no iss_valid; ld_en during RUN leaves imem
//   unchanged; start during RUN ignored.
// - Macro off: repeat distance-1 RAW -> i1 issued the cycle after i0, stall_cnt=0.

Source files
------------

// File: rtl/instr_issue_unit.sv
// Issue stage: loadable instruction memory, PC stepping, field decode and RAW interlock.
// Optional feature macro: HAZARD_STALL_EN enables the rd scoreboard and stall bubbles.
module instr_issue_unit #(
  parameter  int IMEM_DEPTH = 16,
  parameter  int HAZ_DIST   = 2,
  localparam int AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [21:0]   ld_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  output logic          busy,
  output logic          done,
  output logic          iss_valid,
  output logic [3:0]    rs1,
  output logic [3:0]    rs2,
  output logic [3:0]    rd,
  output logic [1:0]    func,
  output logic [7:0]    addr,
  output logic [AW-1:0] pc,
  output logic [15:0]   stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [21:0]   imem [IMEM_DEPTH];
  logic [21:0]   cur_word;
  logic [AW:0]   len_q;
  logic [AW:0]   len_in;
  logic [1:0]    drain_cnt;
  logic          hazard;
  logic          issue;
  logic          last;

  // NOTE: instruction storage has no reset; contents survive rst_n and map to plain RAM.
  always_ff @(posedge clk1) begin
    if (state == S_IDLE && ld_en) imem[ld_addr] <= ld_data;
  end

  assign cur_word = imem[pc];
  assign len_in   = (prog_len > (AW+1)'(IMEM_DEPTH)) ? (AW+1)'(IMEM_DEPTH) : prog_len;
  assign issue    = (state == S_RUN) && !hazard;
  assign last     = issue && (((AW+1)'(pc) + 1'b1) == len_q);
  assign busy     = (state == S_RUN) || (state == S_DRAIN);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (prog_len == '0) ? S_DONE : S_RUN;
      S_RUN:   if (last) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == 2'(HAZ_DIST)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: all clocked state uses non-blocking assignment so every register samples pre-edge values.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid <= 1'b0;
      pc        <= '0;
      len_q     <= '0;
      drain_cnt <= '0;
      func      <= '0;
      rd        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      addr      <= '0;
    end else begin
      iss_valid <= issue;
      if (issue) begin
        func <= cur_word[21:20];
        rd   <= cur_word[19:16];
        rs1  <= cur_word[15:12];
        rs2  <= cur_word[11:8];
        addr <= cur_word[7:0];
        pc   <= pc + 1'b1;
      end
      case (state)
        S_IDLE: if (start && prog_len != '0) begin
          pc    <= '0;
          len_q <= len_in;
        end
        S_RUN:   drain_cnt <= '0;
        S_DRAIN: drain_cnt <= drain_cnt + 2'd1;
        S_DONE:  pc <= '0;
        default: ;
      endcase
    end
  end

`ifdef HAZARD_STALL_EN
  // Slot 0 holds the most recent issue slot, slot HAZ_DIST-1 the oldest still interlocking.
  logic [3:0]          sb_rd [HAZ_DIST];
  logic [HAZ_DIST-1:0] sb_v;

  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < HAZ_DIST; i++) begin
      if (sb_v[i] && (cur_word[15:12] == sb_rd[i] || cur_word[11:8] == sb_rd[i])) hazard = 1'b1;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      sb_v      <= '0;
      stall_cnt <= '0;
      for (int i = 0; i < HAZ_DIST; i++) sb_rd[i] <= '0;
    end else if (state == S_IDLE) begin
      if (start && prog_len != '0) begin
        sb_v      <= '0;
        stall_cnt <= '0;
      end
    end else if (busy) begin
      for (int i = HAZ_DIST - 1; i > 0; i--) begin
        sb_v[i]  <= sb_v[i-1];
        sb_rd[i] <= sb_rd[i-1];
      end
      sb_v[0]  <= issue;
      sb_rd[0] <= cur_word[19:16];
      if (state == S_RUN && hazard && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end
`else
  assign hazard    = 1'b0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed bench for instr_issue_unit: vector table for a clean program plus hazard/edge sequences.
module tb_instr_issue_unit;
  localparam int AW = 4;
`ifdef HAZARD_STALL_EN
  localparam bit HZ = 1'b1;
`else
  localparam bit HZ = 1'b0;
`endif

  logic          clk1 = 1'b0;
  logic          rst_n, ld_en, start;
  logic [AW-1:0] ld_addr;
  logic [21:0]   ld_data;
  logic [AW:0]   prog_len;
  logic          busy, done, iss_valid;
  logic [3:0]    rs1, rs2, rd;
  logic [1:0]    func;
  logic [7:0]    addr;
  logic [AW-1:0] pc;
  logic [15:0]   stall_cnt;

  instr_issue_unit dut (
    .clk1(clk1), .rst_n(rst_n), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .prog_len(prog_len), .busy(busy), .done(done), .iss_valid(iss_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr), .pc(pc), .stall_cnt(stall_cnt)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    logic        busy, done, vld;
    logic [3:0]  pc;
    logic [21:0] word;
    logic [15:0] stall;
  } vec_t;

  vec_t       tbl [8];
  int         checks = 0, failures = 0;
  int         n_iss, done_k, extra;
  int         iss_k [20];
  logic [7:0] iss_addr [20];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  function automatic logic [21:0] ins(input int f, input int d, input int a, input int b, input int ad);
    return {f[1:0], d[3:0], a[3:0], b[3:0], ad[7:0]};
  endfunction

  task automatic load(input int a, input logic [21:0] w);
    ld_en = 1'b1; ld_addr = a[AW-1:0]; ld_data = w;
    tick();
    ld_en = 1'b0;
  endtask

  // Runs a program to its done pulse, logging the cycle (after the start edge) of each issue.
  task automatic run(input logic [AW:0] len, input bit disturb);
    n_iss = 0; done_k = -1;
    prog_len = len; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 60 && done_k < 0; k++) begin
      if (disturb) begin
        ld_en = (k <= 2); start = (k <= 2);
        ld_addr = 4'd1; ld_data = ins(3, 15, 15, 15, 200); prog_len = 5'd5;
      end
      tick();
      if (iss_valid) begin
        if (n_iss < 20) begin iss_k[n_iss] = k; iss_addr[n_iss] = addr; end
        n_iss++;
      end
      if (done) done_k = k;
    end
    ld_en = 1'b0; start = 1'b0;
    check("run_done_seen", 64'(done_k >= 0), 64'd1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 4'd0, 22'd0, 16'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 4'd1, ins(0, 1, 5, 3, 125), 16'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 4'd2, ins(1, 2, 6, 4, 126), 16'd0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 4'd3, ins(0, 3, 7, 5, 127), 16'd0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 4'd3, ins(0, 3, 7, 5, 127), 16'd0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 4'd3, ins(0, 3, 7, 5, 127), 16'd0};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 4'd3, ins(0, 3, 7, 5, 127), 16'd0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 4'd0, ins(0, 3, 7, 5, 127), 16'd0};

    rst_n = 1'b0; ld_en = 1'b0; start = 1'b0; ld_addr = '0; ld_data = '0; prog_len = '0;
    repeat (2) tick();
    check("reset_outputs", {busy, done, iss_valid, pc, stall_cnt, func, rd, rs1, rs2, addr}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Independent program, compared cycle by cycle against the table.
    load(0, ins(0, 1, 5, 3, 125));
    load(1, ins(1, 2, 6, 4, 126));
    load(2, ins(0, 3, 7, 5, 127));
    prog_len = 5'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("indep_cycle%0d", k),
            {busy, done, iss_valid, pc, func, rd, rs1, rs2, addr, stall_cnt},
            {tbl[k].busy, tbl[k].done, tbl[k].vld, tbl[k].pc, tbl[k].word, tbl[k].stall});
      tick();
    end

    // Distance-1 RAW: i1 reads r1 written by i0.
    load(0, ins(0, 1, 2, 3, 10));
    load(1, ins(1, 4, 1, 5, 11));
    run(5'd2, 1'b0);
    check("raw1_count", 64'(n_iss), 64'd2);
    check("raw1_i0_cycle", 64'(iss_k[0]), 64'd1);
    check("raw1_i1_cycle", 64'(iss_k[1]), HZ ? 64'd4 : 64'd2);
    check("raw1_i1_addr", 64'(iss_addr[1]), 64'd11);
    check("raw1_stall_cnt", 64'(stall_cnt), HZ ? 64'd2 : 64'd0);
    check("raw1_done_cycle", 64'(done_k), HZ ? 64'd7 : 64'd5);

    // Distance-2 RAW: i2 reads r1 written by i0, i1 independent.
    load(0, ins(0, 1, 2, 3, 20));
    load(1, ins(0, 6, 7, 8, 21));
    load(2, ins(0, 9, 10, 1, 22));
    run(5'd3, 1'b0);
    check("raw2_count", 64'(n_iss), 64'd3);
    check("raw2_i1_cycle", 64'(iss_k[1]), 64'd2);
    check("raw2_i2_cycle", 64'(iss_k[2]), HZ ? 64'd4 : 64'd3);
    check("raw2_stall_cnt", 64'(stall_cnt), HZ ? 64'd1 : 64'd0);

    // Empty program: done one cycle after start, nothing issued.
    prog_len = 5'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("len0_done", {done, busy, iss_valid}, 64'b100);
    tick();
    check("len0_done_clears", {done, busy, iss_valid}, 64'b000);

    // ld_en and start asserted during RUN must have no effect.
    load(0, ins(0, 1, 5, 3, 125));
    load(1, ins(1, 2, 6, 4, 126));
    load(2, ins(0, 3, 7, 5, 127));
    run(5'd3, 1'b1);
    check("busy_start_count", 64'(n_iss), 64'd3);
    check("busy_start_done_cycle", 64'(done_k), 64'd6);
    check("busy_idle_after", 64'(busy), 64'd0);
    run(5'd3, 1'b0);
    check("busy_ld_imem1", 64'(iss_addr[1]), 64'd126);

    // Over-long program length clamps to the full memory.
    for (int i = 0; i < 16; i++) load(i, ins(2, 15, 0, 0, 40 + i));
    run(5'd20, 1'b0);
    check("clamp_count", 64'(n_iss), 64'd16);
    check("clamp_last_addr", 64'(iss_addr[15]), 64'd55);
    check("clamp_done_cycle", 64'(done_k), 64'd19);
    check("clamp_pc_idle", 64'(pc), 64'd0);

    // Asynchronous reset in the middle of a run.
    prog_len = 5'd16; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("mid_run_active", {busy, iss_valid, pc}, {1'b1, 1'b1, 4'd3});
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_now", {busy, iss_valid, done, pc, stall_cnt}, 64'd0);
    repeat (3) tick();
    check("reset_held", {busy, iss_valid, done, pc, stall_cnt, addr}, 64'd0);
    rst_n = 1'b1;
    extra = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (done || iss_valid || busy) extra++;
    end
    check("no_done_after_abort", 64'(extra), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
